// File: rtl/mem_responder.sv
// Single-port RAM responder: arbitrates fetch and load/store requests, data first.
// Optional wait-cycle timeout with sticky resp_err is built when MEMRESP_TIMEOUT_EN is defined.
module mem_responder #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    IACC,
    DONE
  } state_t;

  state_t      state, state_n;
  logic        kind_i, kind_i_n;
  logic        kind_w, kind_w_n;
  logic        ren_n, wen_n;
  logic        ihit_n, dhit_n;
  logic [31:0] addr_n, store_n;
  logic [31:0] resp, resp_n;
  logic        in_acc;
  logic        tmo;

  assign in_acc = (state == DACC) || (state == IACC);
  assign iload  = resp;
  assign dload  = resp;

`ifdef MEMRESP_TIMEOUT_EN
  logic [7:0] cnt;

  assign tmo = (cnt == 8'(TIMEOUT));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt      <= 8'h0;
      resp_err <= 1'b0;
    end else begin
      if (!in_acc)
        cnt <= 8'h0;
      else if (!ram_ready)
        cnt <= cnt + 8'h1;
      if (in_acc && !ram_ready && tmo)
        resp_err <= 1'b1;
    end
  end
`else
  assign tmo      = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    kind_i_n = kind_i;
    kind_w_n = kind_w;
    ren_n    = 1'b0;
    wen_n    = 1'b0;
    ihit_n   = 1'b0;
    dhit_n   = 1'b0;
    addr_n   = ramaddr;
    store_n  = ramstore;
    resp_n   = resp;
    unique case (state)
      IDLE: begin
        if (dREN || dWEN) begin
          state_n  = DACC;
          kind_i_n = 1'b0;
          kind_w_n = dWEN;
          addr_n   = daddr;
          store_n  = dstore;
          ren_n    = !dWEN;
          wen_n    = dWEN;
        end else if (iREN) begin
          state_n  = IACC;
          kind_i_n = 1'b1;
          kind_w_n = 1'b0;
          addr_n   = iaddr;
          ren_n    = 1'b1;
        end
      end
      DACC, IACC: begin
        if (ram_ready) begin
          state_n = DONE;
          ihit_n  = kind_i;
          dhit_n  = !kind_i;
          if (!kind_w)
            resp_n = ramload;
        end else if (tmo) begin
          state_n = DONE;
          ihit_n  = kind_i;
          dhit_n  = !kind_i;
          resp_n  = 32'hBAD1_BAD1;
        end else begin
          ren_n = !kind_w;
          wen_n = kind_w;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      kind_i   <= 1'b0;
      kind_w   <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      ramaddr  <= 32'h0;
      ramstore <= 32'h0;
      resp     <= 32'h0;
    end else begin
      state    <= state_n;
      kind_i   <= kind_i_n;
      kind_w   <= kind_w_n;
      ramREN   <= ren_n;
      ramWEN   <= wen_n;
      ihit     <= ihit_n;
      dhit     <= dhit_n;
      ramaddr  <= addr_n;
      ramstore <= store_n;
      resp     <= resp_n;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a hit-order scoreboard.
// Timeout step runs only when MEMRESP_TIMEOUT_EN is defined.
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic        ram_ready;
  logic        resp_err;

  typedef struct {
    logic        d;
    logic        chkd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc;
  int   nren;

  always #5 CLK = ~CLK;

  mem_responder #(.TIMEOUT(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .ihit     (ihit),
    .iload    (iload),
    .dhit     (dhit),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ram_ready(ram_ready),
    .resp_err (resp_err)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s got %h want %h", tag, obs, exp);
  endtask

  task automatic push(input logic d, input logic chkd,
                      input logic [31:0] data);
    exp_t e;
    e.d    = d;
    e.chkd = chkd;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic await_hit(input string tag, input int maxc,
                           output int n);
    exp_t e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ihit || dhit) && n < maxc);
    if (!(ihit || dhit)) begin
      chk({tag, "_hit"}, {31'b0, ihit | dhit}, 32'h1);
    end else if (sb.size() == 0) begin
      chk({tag, "_sb"}, 32'(sb.size()), 32'h1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_kind"}, {30'b0, dhit, ihit}, e.d ? 32'h2 : 32'h1);
      if (e.chkd)
        chk({tag, "_data"}, e.d ? dload : iload, e.data);
    end
  endtask

  initial begin
    nRST = 1'b0;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ram_ready = 1'b0;
    tick();
    tick();
    chk("rst_ihit", {31'b0, ihit}, 32'h0);
    chk("rst_dhit", {31'b0, dhit}, 32'h0);
    chk("rst_ren", {30'b0, ramREN, ramWEN}, 32'h0);
    chk("rst_err", {31'b0, resp_err}, 32'h0);
    chk("rst_addr", ramaddr, 32'h0);
    chk("rst_store", ramstore, 32'h0);
    chk("rst_load", iload | dload, 32'h0);
    nRST = 1'b1;
    tick();

    // single fetch
    iREN = 1'b1; iaddr = 32'h40;
    ram_ready = 1'b1; ramload = 32'h3C01_0004;
    push(1'b0, 1'b1, 32'h3C01_0004);
    tick();
    chk("f_ren", {31'b0, ramREN}, 32'h1);
    chk("f_addr", ramaddr, 32'h40);
    await_hit("f", 10, cyc);
    chk("f_lat", 32'(cyc), 32'h1);
    iREN = 1'b0;
    tick();
    chk("f_ihit_lo", {31'b0, ihit}, 32'h0);
    chk("f_ren_lo", {31'b0, ramREN}, 32'h0);

    // simultaneous store + fetch, store first
    iREN = 1'b1; iaddr = 32'h44;
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    ramload = 32'h1111_2222;
    push(1'b1, 1'b0, 32'h0);
    push(1'b0, 1'b1, 32'h1111_2222);
    tick();
    chk("s_wen", {30'b0, ramREN, ramWEN}, 32'h1);
    chk("s_addr", ramaddr, 32'h80);
    chk("s_store", ramstore, 32'hDEAD_BEEF);
    await_hit("s_d", 10, cyc);
    chk("s_dlat", 32'(cyc), 32'h1);
    dWEN = 1'b0;
    await_hit("s_i", 10, cyc);
    chk("s_ilat", 32'(cyc), 32'h3);
    iREN = 1'b0;
    tick();

    // wait states with operand hold
    dREN = 1'b1; daddr = 32'h100;
    ram_ready = 1'b0; ramload = 32'h1234;
    push(1'b1, 1'b1, 32'h1234);
    nren = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (ramREN) nren++;
      if (i == 3) daddr = 32'h200;
      if (i == 6) ram_ready = 1'b1;
    end
    chk("w_hold", ramaddr, 32'h100);
    chk("w_nren", 32'(nren), 32'h6);
    await_hit("w", 10, cyc);
    chk("w_lat", 32'(cyc), 32'h1);
    dREN = 1'b0;
    tick();
    chk("w_once", {31'b0, dhit}, 32'h0);
    chk("w_err", {31'b0, resp_err}, 32'h0);

`ifdef MEMRESP_TIMEOUT_EN
    dREN = 1'b1; daddr = 32'h500; ram_ready = 1'b0;
    push(1'b1, 1'b1, 32'hBAD1_BAD1);
    await_hit("t", 20, cyc);
    chk("t_lat", 32'(cyc), 32'h6);
    chk("t_err", {31'b0, resp_err}, 32'h1);
    dREN = 1'b0;
    tick();
    tick();
    chk("t_sticky", {31'b0, resp_err}, 32'h1);
`endif

    // reset mid-access
    dREN = 1'b1; daddr = 32'h300; ram_ready = 1'b0;
    tick();
    chk("r_ren", {31'b0, ramREN}, 32'h1);
    tick();
    #2 nRST = 1'b0;
    #1;
    chk("r_async_ren", {31'b0, ramREN}, 32'h0);
    chk("r_async_addr", ramaddr, 32'h0);
    chk("r_async_err", {31'b0, resp_err}, 32'h0);
    dREN = 1'b0;
    ram_ready = 1'b1;
    tick();
    nRST = 1'b1;
    cyc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dhit || ihit || ramREN) cyc++;
    end
    chk("r_quiet", 32'(cyc), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
